// File: rtl/switch_port_arbiter.sv
// Round-robin arbiter sharing one switch output port among NUM_OF_PORTS valid/ready
// burst sources; a grant is held until the last beat or until MAX_BURST beats have moved.
module switch_port_arbiter #(
  parameter int NUM_OF_PORTS = 42,
  parameter int DATA_WIDTH   = 64,
  parameter int MAX_BURST    = 16,
  parameter int IDX_W        = $clog2(NUM_OF_PORTS)
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [NUM_OF_PORTS-1:0]            req_valid,
  input  logic [NUM_OF_PORTS*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_OF_PORTS-1:0]            req_last,
  output logic [NUM_OF_PORTS-1:0]            req_ready,
  output logic                               out_valid,
  output logic [DATA_WIDTH-1:0]              out_data,
  output logic                               out_last,
  input  logic                               out_ready,
  output logic                               grant_active,
  output logic [IDX_W-1:0]                   grant_idx,
  output logic                               burst_trunc
);
  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam int CW    = IDX_W + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);
  localparam logic [IDX_W-1:0] IDX_MAX  = IDX_W'(NUM_OF_PORTS - 1);

  typedef enum logic [0:0] {IDLE = 1'b0, GRANT = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0] grant_idx_q, grant_idx_d;
  logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
  logic             burst_trunc_q, burst_trunc_d;
  logic [IDX_W-1:0] pick_idx;
  logic             g_valid, g_last, xfer;
  logic [DATA_WIDTH-1:0] g_data;

  // Round-robin pick: first valid requester at or after rr_ptr, wrapping to 0.
  always_comb begin
    logic          found;
    logic [CW-1:0] cand;
    found    = 1'b0;
    cand     = '0;
    pick_idx = rr_ptr_q;
    for (int k = 0; k < NUM_OF_PORTS; k++) begin
      cand = {1'b0, rr_ptr_q} + CW'(k);
      if (cand >= CW'(NUM_OF_PORTS)) begin
        cand = cand - CW'(NUM_OF_PORTS);
      end else begin
        cand = cand;
      end
      if (!found && req_valid[cand[IDX_W-1:0]]) begin
        found    = 1'b1;
        pick_idx = cand[IDX_W-1:0];
      end else begin
        found    = found;
      end
    end
  end

  // Signals of the currently granted requester.
  always_comb begin
    g_valid = req_valid[grant_idx_q];
    g_last  = req_last[grant_idx_q];
    g_data  = req_data[int'(grant_idx_q) * DATA_WIDTH +: DATA_WIDTH];
  end

  // Next-state and pass-through output logic.
  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    grant_idx_d   = grant_idx_q;
    beat_cnt_d    = beat_cnt_q;
    burst_trunc_d = 1'b0;
    out_valid     = 1'b0;
    out_data      = '0;
    out_last      = 1'b0;
    req_ready     = '0;
    xfer          = 1'b0;
    case (state_q)
      IDLE: begin
        if (|req_valid) begin
          grant_idx_d = pick_idx;
          beat_cnt_d  = '0;
          state_d     = GRANT;
        end else begin
          state_d     = IDLE;
        end
      end
      GRANT: begin
        out_valid              = g_valid;
        out_data               = g_valid ? g_data : '0;
        out_last               = g_last | (beat_cnt_q == CNT_LAST);
        req_ready[grant_idx_q] = out_ready;
        xfer                   = g_valid & out_ready;
        if (xfer && out_last) begin
          // A release without req_last means the beat limit cut the burst.
          state_d       = IDLE;
          rr_ptr_d      = (grant_idx_q == IDX_MAX) ? '0 : grant_idx_q + IDX_W'(1);
          beat_cnt_d    = '0;
          burst_trunc_d = ~g_last;
        end else if (xfer) begin
          beat_cnt_d    = beat_cnt_q + CNT_W'(1);
        end else begin
          beat_cnt_d    = beat_cnt_q;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      rr_ptr_q      <= '0;
      grant_idx_q   <= '0;
      beat_cnt_q    <= '0;
      burst_trunc_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      rr_ptr_q      <= rr_ptr_d;
      grant_idx_q   <= grant_idx_d;
      beat_cnt_q    <= beat_cnt_d;
      burst_trunc_q <= burst_trunc_d;
    end
  end

  assign grant_active = (state_q == GRANT);
  assign grant_idx    = grant_idx_q;
  assign burst_trunc  = burst_trunc_q;

endmodule

// File: tb/tb_switch_port_arbiter.sv
// Bench for switch_port_arbiter: per-requester beat queues, a transaction-level
// reference model, directed scenarios and a randomized contention run.
module tb_switch_port_arbiter;
  localparam int N  = 42;
  localparam int W  = 64;
  localparam int MB = 16;
  localparam int IW = $clog2(N);

  logic            clk;
  logic            rst_n;
  logic [N-1:0]    req_valid, req_last, req_ready;
  logic [N*W-1:0]  req_data;
  logic            out_valid, out_last, out_ready, grant_active, burst_trunc;
  logic [W-1:0]    out_data;
  logic [IW-1:0]   grant_idx;

  switch_port_arbiter #(.NUM_OF_PORTS(N), .DATA_WIDTH(W), .MAX_BURST(MB)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_data(req_data), .req_last(req_last), .req_ready(req_ready),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_ready(out_ready),
    .grant_active(grant_active), .grant_idx(grant_idx), .burst_trunc(burst_trunc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks;
  int n_errors;

  // Pending beats of each requester, front = beat currently presented.
  logic [W-1:0] qd [N][$];
  bit           ql [N][$];
  logic [N-1:0] hold_mask;
  int           ready_mode;
  bit           rnd_valid;
  int           cyc;

  // Reference model: who holds the port, beats taken in this grant, scan start.
  bit m_busy;
  int m_g;
  int m_cnt;
  int m_ptr;
  bit m_trunc;

  // Observed DUT events.
  int           obs_grants[$];
  int           obs_cyc[$];
  logic [W-1:0] obs_data[$];
  bit           obs_last[$];
  int           trunc_cnt;
  bit           prev_ga;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic int pick(input logic [N-1:0] v);
    for (int k = 0; k < N; k++) begin
      if (v[(m_ptr + k) % N]) return (m_ptr + k) % N;
    end
    return -1;
  endfunction

  function automatic bit pending();
    for (int i = 0; i < N; i++) begin
      if (qd[i].size() > 0) return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic int gget(input int i);
    return (i < obs_grants.size()) ? obs_grants[i] : -1;
  endfunction

  function automatic logic [W-1:0] dget(input int i);
    return (i < obs_data.size()) ? obs_data[i] : {W{1'b1}};
  endfunction

  function automatic bit lget(input int i);
    return (i < obs_last.size()) ? obs_last[i] : 1'b0;
  endfunction

  task automatic load_burst(input int r, input int len, input logic [W-1:0] base);
    for (int b = 0; b < len; b++) begin
      qd[r].push_back(base + W'(b));
      ql[r].push_back(b == len - 1);
    end
  endtask

  task automatic clear_obs();
    obs_grants.delete();
    obs_cyc.delete();
    obs_data.delete();
    obs_last.delete();
    trunc_cnt = 0;
  endtask

  // One clock cycle, starting and ending at a falling edge.
  task automatic step(input bit in_reset);
    logic [N-1:0] v, l;
    logic         rdy;
    logic [W-1:0] ed;
    bit           ev, el, nt;
    int           g;
    for (int i = 0; i < N; i++) begin
      v[i] = (qd[i].size() > 0) && !hold_mask[i] && (!rnd_valid || $urandom_range(0, 3) != 0);
      l[i] = (qd[i].size() > 0) ? ql[i][0] : (rnd_valid ? 1'($urandom_range(0, 1)) : 1'b0);
      req_data[i*W +: W] = v[i] ? qd[i][0] : (rnd_valid ? {$urandom, $urandom} : '0);
    end
    case (ready_mode)
      0:       rdy = 1'b1;
      1:       rdy = ($urandom_range(0, 3) != 0);
      2:       rdy = (cyc % 2 == 0);
      default: rdy = 1'b0;
    endcase
    req_valid = v;
    req_last  = l;
    out_ready = rdy;
    #1;
    if (!in_reset) begin
      ev = m_busy && v[m_g];
      el = m_busy && (l[m_g] || m_cnt == MB - 1);
      ed = ev ? qd[m_g][0] : '0;
      chk("grant_active", grant_active, m_busy);
      chk("burst_trunc", burst_trunc, m_trunc);
      chk("out_valid", out_valid, ev);
      chk("out_data", out_data, ed);
      chk("out_last", out_last, el);
      chk("req_ready", req_ready, (m_busy && rdy) ? (N'(1) << m_g) : '0);
      if (m_busy) chk("grant_idx", grant_idx, m_g);
      if (grant_active && !prev_ga) obs_grants.push_back(int'(grant_idx));
      prev_ga = grant_active;
      if (out_valid && out_ready) begin
        obs_cyc.push_back(cyc);
        obs_data.push_back(out_data);
        obs_last.push_back(out_last);
      end
      if (burst_trunc) trunc_cnt++;
      nt = 1'b0;
      if (!m_busy) begin
        if (|v) begin
          g      = pick(v);
          m_busy = 1'b1;
          m_g    = g;
          m_cnt  = 0;
        end
      end else if (ev && rdy) begin
        void'(qd[m_g].pop_front());
        void'(ql[m_g].pop_front());
        if (el) begin
          m_busy = 1'b0;
          m_ptr  = (m_g + 1) % N;
          nt     = !l[m_g];
        end else begin
          m_cnt++;
        end
      end
      m_trunc = nt;
    end else begin
      m_busy  = 1'b0;
      m_ptr   = 0;
      m_cnt   = 0;
      m_trunc = 1'b0;
      prev_ga = 1'b0;
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    repeat (n) step(1'b1);
    rst_n = 1'b1;
  endtask

  task automatic drain(input int budget);
    int c;
    c = 0;
    while ((pending() || m_busy) && c < budget) begin
      step(1'b0);
      c++;
    end
    chk("drain_done", pending() || m_busy, 1'b0);
    step(1'b0);
    step(1'b0);
  endtask

  initial begin
    int t_start;
    int total;
    int r;
    int exp2[6];
    int exp3[6];
    n_checks   = 0;
    n_errors   = 0;
    rst_n      = 1'b0;
    req_valid  = '0;
    req_last   = '0;
    req_data   = '0;
    out_ready  = 1'b0;
    hold_mask  = '0;
    ready_mode = 3;
    rnd_valid  = 1'b0;
    cyc        = 0;
    m_busy     = 1'b0;
    m_g        = 0;
    m_cnt      = 0;
    m_ptr      = 0;
    m_trunc    = 1'b0;
    prev_ga    = 1'b0;
    clear_obs();
    @(negedge clk);
    do_reset(2);

    // Idle after reset with every input low.
    repeat (10) step(1'b0);
    chk("idle_grant_idx", grant_idx, '0);

    // Requester 3: four beats A0..A3.
    ready_mode = 0;
    clear_obs();
    t_start = cyc;
    load_burst(3, 4, 64'hA0);
    drain(100);
    chk("t1_grant", gget(0), 3);
    chk("t1_beats", obs_data.size(), 4);
    chk("t1_first_beat_cycle", obs_cyc.size() > 0 ? obs_cyc[0] : -1, t_start + 1);
    chk("t1_consecutive", obs_cyc.size() == 4 ? obs_cyc[3] - obs_cyc[0] : -1, 3);
    for (int k = 0; k < 4; k++) chk($sformatf("t1_data%0d", k), dget(k), 64'hA0 + W'(k));
    chk("t1_last3", lget(3), 1'b1);
    chk("t1_last2", lget(2), 1'b0);
    // Scan now starts at 4: requester 5 beats requester 2.
    load_burst(2, 1, 64'h2);
    load_burst(5, 1, 64'h5);
    drain(100);
    chk("t1_next_scan", gget(1), 5);
    chk("t1_after", gget(2), 2);

    // Requesters 0, 5, 41 with single-beat bursts; order wraps 41 -> 0.
    do_reset(1);
    clear_obs();
    for (int k = 0; k < 2; k++) begin
      load_burst(0, 1, 64'h100 + W'(k));
      load_burst(5, 1, 64'h500 + W'(k));
      load_burst(41, 1, 64'h4100 + W'(k));
    end
    drain(100);
    exp2 = '{0, 5, 41, 0, 5, 41};
    for (int k = 0; k < 6; k++) chk($sformatf("t2_grant%0d", k), gget(k), exp2[k]);

    // Requester 2 streams 40 beats; requester 7 slips in between 16-beat slices.
    clear_obs();
    load_burst(2, 40, 64'h200);
    for (int k = 0; k < 3; k++) load_burst(7, 1, 64'h700 + W'(k));
    drain(400);
    exp3 = '{2, 7, 2, 7, 2, 7};
    for (int k = 0; k < 6; k++) chk($sformatf("t3_grant%0d", k), gget(k), exp3[k]);
    chk("t3_trunc_pulses", trunc_cnt, 2);
    chk("t3_last16", lget(15), 1'b1);
    chk("t3_data16", dget(15), 64'h20F);
    chk("t3_r7", dget(16), 64'h700);
    chk("t3_last32", lget(32), 1'b1);
    chk("t3_data32", dget(32), 64'h21F);

    // Stall mix: out_ready toggles, requester 9 drops valid for 3 cycles.
    ready_mode = 2;
    clear_obs();
    load_burst(9, 8, 64'h900);
    load_burst(10, 1, 64'hA00);
    repeat (6) step(1'b0);
    hold_mask[9] = 1'b1;
    repeat (3) step(1'b0);
    hold_mask[9] = 1'b0;
    drain(200);
    chk("t4_grant0", gget(0), 9);
    chk("t4_grant1", gget(1), 10);
    chk("t4_grants", obs_grants.size(), 2);
    chk("t4_beats", obs_data.size(), 9);
    for (int k = 0; k < 8; k++) chk($sformatf("t4_data%0d", k), dget(k), 64'h900 + W'(k));
    chk("t4_data8", dget(8), 64'hA00);

    // Reset during beat 3 of a burst; the next grant scans from 0.
    ready_mode = 0;
    clear_obs();
    load_burst(20, 6, 64'hB00);
    load_burst(2, 1, 64'hC00);
    t_start = 0;
    while (obs_data.size() < 2 && t_start < 50) begin
      step(1'b0);
      t_start++;
    end
    do_reset(1);
    step(1'b0);
    chk("t5_no_beat_after_reset", obs_data.size(), 2);
    drain(100);
    chk("t5_grant0", gget(0), 20);
    chk("t5_grant_after_reset", gget(1), 2);
    chk("t5_grant2", gget(2), 20);
    chk("t5_data2", dget(2), 64'hC00);
    chk("t5_data3", dget(3), 64'hB02);

    // Randomized contention with valid gaps and random backpressure.
    do_reset(1);
    clear_obs();
    rnd_valid  = 1'b1;
    ready_mode = 1;
    total      = 0;
    for (int j = 0; j < 6; j++) begin
      r = (j == 0) ? 0 : (j == 1) ? N - 1 : $urandom_range(0, N - 1);
      for (int b = 0; b < $urandom_range(1, 3); b++) begin
        int len;
        len = $urandom_range(1, 40);
        load_burst(r, len, {$urandom, $urandom});
        total += len;
      end
    end
    drain(20000);
    chk("t6_beat_count", obs_data.size(), total);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
